// File: rtl/uart_registers_fifo_level.sv
// uart_registers_fifo_level: UART register bank with RX/TX FIFOs, level thresholds, idle timeout and W1C interrupts.
module uart_registers_fifo_level #(
  parameter int RX_DEPTH        = 64,
  parameter int TX_DEPTH        = 64,
  parameter int DEFAULT_DIVIDER = 53
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        interrupt_o,
  input  logic        baud_tick_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_done_i,
  input  logic        rx_error_i,
  output logic        rx_rts_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic        tx_done_i,
  output logic [1:0]  data_lenght_o,
  output logic        stop_bits_o,
  output logic        parity_mode_o,
  output logic        parity_enable_o,
  output logic        tx_enable_o,
  output logic        rx_enable_o,
  output logic        flow_control_o,
  output logic [14:0] divider_o,
  input  logic        write_i,
  input  logic [2:0]  write_address_i,
  input  logic [31:0] write_data_i,
  input  logic [3:0]  write_strobe_i,
  output logic        write_error_o,
  input  logic        read_i,
  input  logic [2:0]  read_address_i,
  output logic [31:0] read_data_o,
  output logic        read_error_o
);
  localparam int CNT_W = $clog2((RX_DEPTH > TX_DEPTH) ? RX_DEPTH : TX_DEPTH) + 1;
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam logic [31:0] CFG_MASK = 32'h007F_FFFF;
  localparam logic [31:0] THR_MASK = 32'hFFFF_03FF;
  localparam logic [31:0] CFG_RST = {9'd0, 15'(DEFAULT_DIVIDER), 8'h64};
  localparam logic [31:0] THR_RST = {6'd40, 16'd0, 10'(RX_DEPTH / 2)};
  typedef enum logic [1:0] {IDLE, COUNT, FIRED} to_state_t;
  logic [31:0] cfg, thr, status;
  logic [7:0] int_en, int_pend, ev, clr;
  logic [7:0] rx_mem [RX_DEPTH];
  logic [7:0] tx_mem [TX_DEPTH];
  logic [RAW-1:0] rx_wr, rx_rd;
  logic [TAW-1:0] tx_wr, tx_rd;
  logic [CNT_W-1:0] rx_level, tx_level;
  logic [9:0] rx_lvl, tx_lvl;
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, rx_wen, tx_push, tx_pop, tx_wen;
  logic rx_cond, tx_cond, rx_cond_q, tx_cond_q, reload, to_fire;
  to_state_t to_state, to_state_n;
  logic [5:0] to_cnt, to_cnt_n;
  assign rx_lvl = 10'(rx_level);
  assign tx_lvl = 10'(tx_level);
  assign rx_empty = rx_level == '0;
  assign tx_empty = tx_level == '0;
  assign rx_full = rx_level == CNT_W'(RX_DEPTH);
  assign tx_full = tx_level == CNT_W'(TX_DEPTH);
  assign write_error_o = write_i & (write_address_i == 3'd2 | write_address_i == 3'd3 | write_address_i == 3'd7);
  assign read_error_o = read_i & (read_address_i == 3'd1 | read_address_i == 3'd7 | (read_address_i == 3'd2 & rx_empty));
  assign rx_pop = read_i & read_address_i == 3'd2 & ~rx_empty;
  assign rx_push = rx_done_i & cfg[0];
  assign rx_wen = rx_push & (~rx_full | rx_pop);
  assign tx_valid_o = ~tx_empty & cfg[1];
  assign tx_pop = tx_valid_o & tx_ready_i;
  assign tx_push = write_i & write_address_i == 3'd1 & write_strobe_i[0];
  assign tx_wen = tx_push & (~tx_full | tx_pop);
  assign tx_data_o = tx_mem[tx_rd];
  assign rx_rts_o = cfg[7] & (rx_level < CNT_W'(RX_DEPTH - 2));
  assign {flow_control_o, data_lenght_o, stop_bits_o, parity_mode_o, parity_enable_o, tx_enable_o, rx_enable_o} = cfg[7:0];
  assign divider_o = cfg[22:8];
  assign status = {4'd0, tx_full, tx_empty, tx_lvl, 4'd0, rx_full, rx_empty, rx_lvl};
  assign read_data_o = read_error_o ? 32'd0 :
                       read_address_i == 3'd0 ? cfg :
                       read_address_i == 3'd2 ? {24'd0, rx_mem[rx_rd]} :
                       read_address_i == 3'd3 ? status :
                       read_address_i == 3'd4 ? thr :
                       read_address_i == 3'd5 ? {24'd0, int_en} :
                       read_address_i == 3'd6 ? {24'd0, int_pend} : 32'd0;
  assign rx_cond = rx_lvl >= thr[9:0];
  assign tx_cond = tx_lvl <= thr[25:16];
  assign reload = rx_done_i | rx_pop;
  assign ev = {tx_push & tx_full & ~tx_pop, rx_push & rx_full & ~rx_pop, to_fire, rx_error_i,
               tx_cond & ~tx_cond_q, rx_cond & ~rx_cond_q, tx_done_i, rx_done_i};
  assign clr = (write_i & write_address_i == 3'd6 & write_strobe_i[0]) ? write_data_i[7:0] : 8'd0;
  // Timeout restarts on any RX activity and fires once per idle stretch.
  always_comb begin
    to_state_n = to_state;
    to_cnt_n = to_cnt;
    to_fire = 1'b0;
    if (rx_empty || thr[31:26] == 6'd0) begin
      to_state_n = IDLE;
      to_cnt_n = 6'd0;
    end else if (to_state == IDLE || reload) begin
      to_state_n = COUNT;
      to_cnt_n = 6'd0;
    end else if (to_state == COUNT && baud_tick_i) begin
      to_cnt_n = to_cnt + 6'd1;
      to_fire = (to_cnt + 6'd1) == thr[31:26];
      to_state_n = to_fire ? FIRED : COUNT;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg <= CFG_RST;
      thr <= THR_RST;
      int_en <= 8'd0;
      int_pend <= 8'd0;
      interrupt_o <= 1'b0;
      rx_cond_q <= 1'b0;
      tx_cond_q <= 1'b1;
      to_state <= IDLE;
      to_cnt <= 6'd0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (write_i & write_strobe_i[i]) begin
          if (write_address_i == 3'd0) cfg[8*i +: 8] <= write_data_i[8*i +: 8] & CFG_MASK[8*i +: 8];
          if (write_address_i == 3'd4) thr[8*i +: 8] <= write_data_i[8*i +: 8] & THR_MASK[8*i +: 8];
        end
      if (write_i & write_strobe_i[0] & write_address_i == 3'd5) int_en <= write_data_i[7:0];
      int_pend <= (int_pend & ~clr) | ev;
      interrupt_o <= |(int_pend & int_en);
      rx_cond_q <= rx_cond;
      tx_cond_q <= tx_cond;
      to_state <= to_state_n;
      to_cnt <= to_cnt_n;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_wr <= '0;
      rx_rd <= '0;
      rx_level <= '0;
      tx_wr <= '0;
      tx_rd <= '0;
      tx_level <= '0;
    end else begin
      rx_wr <= rx_wr + RAW'(rx_wen);
      rx_rd <= rx_rd + RAW'(rx_pop);
      rx_level <= rx_level + CNT_W'(rx_wen) - CNT_W'(rx_pop);
      tx_wr <= tx_wr + TAW'(tx_wen);
      tx_rd <= tx_rd + TAW'(tx_pop);
      tx_level <= tx_level + CNT_W'(tx_wen) - CNT_W'(tx_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (rx_wen) rx_mem[rx_wr] <= rx_data_i;
    if (tx_wen) tx_mem[tx_wr] <= write_data_i[7:0];
  end
endmodule

// File: tb/tb_uart_registers_fifo_level.sv
// tb_uart_registers_fifo_level: directed plus random stimulus against a queue-based reference model.
module tb_uart_registers_fifo_level;
  localparam int RXD = 64;
  localparam int TXD = 64;
  logic clk_i = 1'b0, rst_i;
  logic interrupt_o, baud_tick_i, rx_done_i, rx_error_i, rx_rts_o, tx_valid_o, tx_ready_i, tx_done_i;
  logic [7:0] rx_data_i, tx_data_o;
  logic [1:0] data_lenght_o;
  logic stop_bits_o, parity_mode_o, parity_enable_o, tx_enable_o, rx_enable_o, flow_control_o;
  logic [14:0] divider_o;
  logic write_i, write_error_o, read_i, read_error_o;
  logic [2:0] write_address_i, read_address_i;
  logic [31:0] write_data_i, read_data_o, last_rd;
  logic [3:0] write_strobe_i;
  logic last_re;
  int vectors = 0, miscompares = 0;
  logic [7:0] rxq[$], txq[$];
  logic [31:0] m_cfg, m_thr;
  logic [7:0] m_ie, m_pend;
  bit m_irq, m_rxc, m_txc;
  int m_to, m_cnt;
  uart_registers_fifo_level dut (
    .clk_i(clk_i), .rst_i(rst_i), .interrupt_o(interrupt_o), .baud_tick_i(baud_tick_i),
    .rx_data_i(rx_data_i), .rx_done_i(rx_done_i), .rx_error_i(rx_error_i), .rx_rts_o(rx_rts_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_done_i(tx_done_i),
    .data_lenght_o(data_lenght_o), .stop_bits_o(stop_bits_o), .parity_mode_o(parity_mode_o),
    .parity_enable_o(parity_enable_o), .tx_enable_o(tx_enable_o), .rx_enable_o(rx_enable_o),
    .flow_control_o(flow_control_o), .divider_o(divider_o), .write_i(write_i),
    .write_address_i(write_address_i), .write_data_i(write_data_i), .write_strobe_i(write_strobe_i),
    .write_error_o(write_error_o), .read_i(read_i), .read_address_i(read_address_i),
    .read_data_o(read_data_o), .read_error_o(read_error_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    rxq.delete();
    txq.delete();
    m_cfg = 32'h0000_3564;
    m_thr = 32'hA000_0020;
    m_ie = 8'd0;
    m_pend = 8'd0;
    m_irq = 1'b0;
    m_rxc = 1'b0;
    m_txc = 1'b1;
    m_to = 0;
    m_cnt = 0;
  endtask
  function automatic logic [31:0] exp_reg(input logic [2:0] a);
    logic [9:0] rl, tl;
    rl = 10'(rxq.size());
    tl = 10'(txq.size());
    case (a)
      3'd0: return m_cfg;
      3'd2: if (rxq.size() > 0) return {24'd0, rxq[0]}; else return 32'd0;
      3'd3: return {4'd0, tl == TXD, tl == 0, tl, 4'd0, rl == RXD, rl == 0, rl};
      3'd4: return m_thr;
      3'd5: return {24'd0, m_ie};
      3'd6: return {24'd0, m_pend};
      default: return 32'd0;
    endcase
  endfunction
  // Reference: one clock of the register bank, applied from the current inputs.
  task automatic model_step();
    logic [7:0] ev, clr;
    logic [31:0] wmask;
    bit rpop, rpush, tpop, tpush, rc, tc, reload;
    int rl, tl, tmo;
    rl = rxq.size();
    tl = txq.size();
    tmo = int'(m_thr[31:26]);
    rpop = read_i && read_address_i == 3'd2 && rl > 0;
    rpush = rx_done_i && m_cfg[0];
    tpop = tl > 0 && m_cfg[1] && tx_ready_i;
    tpush = write_i && write_address_i == 3'd1 && write_strobe_i[0];
    reload = rx_done_i || rpop;
    ev = 8'd0;
    ev[0] = rx_done_i;
    ev[1] = tx_done_i;
    ev[4] = rx_error_i;
    ev[6] = rpush && rl == RXD && !rpop;
    ev[7] = tpush && tl == TXD && !tpop;
    rc = rl >= int'(m_thr[9:0]);
    tc = tl <= int'(m_thr[25:16]);
    ev[2] = rc && !m_rxc;
    ev[3] = tc && !m_txc;
    m_rxc = rc;
    m_txc = tc;
    if (rl == 0 || tmo == 0) begin m_to = 0; m_cnt = 0; end
    else if (m_to == 0 || reload) begin m_to = 1; m_cnt = 0; end
    else if (m_to == 1 && baud_tick_i) begin
      m_cnt = (m_cnt + 1) % 64;
      if (m_cnt == tmo) begin ev[5] = 1'b1; m_to = 2; end
    end
    m_irq = |(m_pend & m_ie);
    clr = (write_i && write_address_i == 3'd6 && write_strobe_i[0]) ? write_data_i[7:0] : 8'd0;
    m_pend = (m_pend & ~clr) | ev;
    if (rpop) void'(rxq.pop_front());
    if (rpush && !ev[6]) rxq.push_back(rx_data_i);
    if (tpop) void'(txq.pop_front());
    if (tpush && !ev[7]) txq.push_back(write_data_i[7:0]);
    wmask = {{8{write_strobe_i[3]}}, {8{write_strobe_i[2]}}, {8{write_strobe_i[1]}}, {8{write_strobe_i[0]}}};
    if (write_i && write_address_i == 3'd0) m_cfg = ((m_cfg & ~wmask) | (write_data_i & wmask)) & 32'h007F_FFFF;
    if (write_i && write_address_i == 3'd4) m_thr = ((m_thr & ~wmask) | (write_data_i & wmask)) & 32'hFFFF_03FF;
    if (write_i && write_address_i == 3'd5 && write_strobe_i[0]) m_ie = write_data_i[7:0];
  endtask
  task automatic cyc();
    bit exp_re;
    @(negedge clk_i);
    exp_re = read_i && (read_address_i inside {3'd1, 3'd7} || (read_address_i == 3'd2 && rxq.size() == 0));
    last_rd = read_data_o;
    last_re = read_error_o;
    chk("wr_err", write_error_o, write_i && write_address_i inside {3'd2, 3'd3, 3'd7});
    chk("rd_err", read_error_o, exp_re);
    if (read_i) chk("rd_data", read_data_o, exp_re ? 32'd0 : exp_reg(read_address_i));
    chk("irq", interrupt_o, m_irq);
    chk("tx_valid", tx_valid_o, txq.size() > 0 && m_cfg[1]);
    if (txq.size() > 0) chk("tx_data", tx_data_o, txq[0]);
    chk("rts", rx_rts_o, m_cfg[7] && rxq.size() < RXD - 2);
    chk("cfg_out", {flow_control_o, data_lenght_o, stop_bits_o, parity_mode_o, parity_enable_o, tx_enable_o, rx_enable_o}, m_cfg[7:0]);
    chk("divider", divider_o, m_cfg[22:8]);
    model_step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    write_i = 1'b1; write_address_i = a; write_data_i = d; write_strobe_i = s;
    cyc();
    write_i = 1'b0; write_strobe_i = 4'd0;
  endtask
  task automatic rd(input logic [2:0] a);
    read_i = 1'b1; read_address_i = a;
    cyc();
    read_i = 1'b0;
  endtask
  task automatic rxp(input logic [7:0] d);
    rx_done_i = 1'b1; rx_data_i = d;
    cyc();
    rx_done_i = 1'b0;
  endtask
  task automatic tick();
    baud_tick_i = 1'b1;
    cyc();
    baud_tick_i = 1'b0;
  endtask
  task automatic clr_in();
    write_i = 0; read_i = 0; rx_done_i = 0; rx_error_i = 0; tx_done_i = 0; baud_tick_i = 0;
    write_strobe_i = 0; write_address_i = 0; read_address_i = 0; write_data_i = 0; rx_data_i = 0;
  endtask
  initial begin
    clr_in();
    tx_ready_i = 1'b0;
    rst_i = 1'b1;
    read_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("rst_tx_valid", tx_valid_o, 0);
    chk("rst_irq", interrupt_o, 0);
    chk("rst_rts", rx_rts_o, 0);
    chk("rst_config", read_data_o, 32'h0000_3564);
    read_address_i = 3'd4;
    #1;
    chk("rst_threshold", read_data_o, 32'hA000_0020);
    read_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    m_reset();
    // RX fill to full plus one overflow, then drain in order
    wr(3'd0, 32'h0000_3565, 4'b0001);
    for (int i = 0; i <= RXD; i++) rxp(8'(i));
    rd(3'd3);
    chk("rx_full_status", last_rd[11:0], 12'h840);
    rd(3'd6);
    chk("rx_ovf_pend", last_rd[6], 1);
    for (int i = 0; i < RXD; i++) begin
      rd(3'd2);
      chk("rx_order", last_rd[7:0], 8'(i));
    end
    rd(3'd2);
    chk("rx_empty_err", last_re, 1);
    chk("rx_empty_data", last_rd, 0);
    wr(3'd3, 32'hFFFF_FFFF, 4'hF);
    rd(3'd7);
    chk("rd7_err", last_re, 1);
    // RX level threshold interrupt
    wr(3'd4, 32'd4, 4'b0001);
    wr(3'd6, 32'hFF, 4'b0001);
    wr(3'd5, 32'h04, 4'b0001);
    for (int i = 0; i < 4; i++) rxp(8'(8'h30 + i));
    cyc();
    chk("thr_irq_low", interrupt_o, 0);
    rd(3'd6);
    chk("thr_pend", last_rd[2], 1);
    chk("thr_irq_high", interrupt_o, 1);
    wr(3'd6, 32'h04, 4'b0001);
    cyc();
    chk("w1c_irq_low", interrupt_o, 0);
    rxp(8'h34);
    cyc();
    rd(3'd6);
    chk("thr_no_reset", last_rd[2], 0);
    // idle timeout
    for (int i = 0; i < 5; i++) rd(3'd2);
    wr(3'd4, 32'h0C00_0000, 4'b1000);
    rxp(8'hA5);
    cyc();
    cyc();
    wr(3'd6, 32'hFF, 4'b0001);
    tick();
    tick();
    rd(3'd6);
    chk("to_early", last_rd[5], 0);
    tick();
    rd(3'd6);
    chk("to_fire", last_rd[5], 1);
    wr(3'd6, 32'hFF, 4'b0001);
    repeat (5) tick();
    rd(3'd6);
    chk("to_once", last_rd[5], 0);
    rd(3'd2);
    repeat (5) tick();
    rd(3'd6);
    chk("to_idle", last_rd[5], 0);
    // TX full: simultaneous pop+push vs overflow
    for (int i = 0; i < TXD; i++) wr(3'd1, 32'(i), 4'b0001);
    wr(3'd6, 32'hFF, 4'b0001);
    wr(3'd0, 32'h67, 4'b0001);
    tx_ready_i = 1'b1;
    wr(3'd1, 32'hEE, 4'b0001);
    tx_ready_i = 1'b0;
    rd(3'd3);
    chk("tx_full_keep", last_rd[27:16], 12'h840);
    rd(3'd6);
    chk("tx_no_ovf", last_rd[7], 0);
    wr(3'd1, 32'hEF, 4'b0001);
    rd(3'd6);
    chk("tx_ovf", last_rd[7], 1);
    tx_ready_i = 1'b1;
    for (int k = 0; k < 200 && txq.size() > 0; k++) cyc();
    chk("tx_drain", tx_valid_o, 0);
    // random traffic
    for (int n = 0; n < 1500; n++) begin
      rx_done_i = $urandom % 4 == 0;
      rx_data_i = 8'($urandom);
      rx_error_i = $urandom % 20 == 0;
      tx_done_i = $urandom % 20 == 0;
      tx_ready_i = 1'($urandom);
      baud_tick_i = $urandom % 3 == 0;
      write_i = $urandom % 4 == 0;
      write_address_i = 3'($urandom);
      write_data_i = $urandom;
      write_strobe_i = 4'($urandom);
      read_i = 1'($urandom);
      read_address_i = 3'($urandom);
      cyc();
    end
    clr_in();
    // asynchronous reset mid-burst
    wr(3'd0, 32'h0000_35E7, 4'hF);
    tx_ready_i = 1'b1;
    for (int k = 0; k < 200 && txq.size() > 0; k++) cyc();
    tx_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) wr(3'd1, 32'(8'h50 + i), 4'b0001);
    wr(3'd5, 32'hFF, 4'b0001);
    tx_done_i = 1'b1;
    cyc();
    tx_done_i = 1'b0;
    cyc();
    chk("pre_rst_irq", interrupt_o, 1);
    chk("pre_rst_valid", tx_valid_o, 1);
    read_i = 1'b1;
    read_address_i = 3'd3;
    #2 rst_i = 1'b1;
    #1;
    chk("arst_tx_valid", tx_valid_o, 0);
    chk("arst_irq", interrupt_o, 0);
    chk("arst_rts", rx_rts_o, 0);
    chk("arst_status", read_data_o, 32'h0400_0400);
    read_i = 1'b0;
    m_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    rd(3'd0);
    chk("post_rst_cfg", last_rd, 32'h0000_3564);
    rd(3'd4);
    chk("post_rst_thr", last_rd, 32'hA000_0020);
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
